// File: rtl/div_seq_32_if.sv
// rtl/div_seq_32_if.sv - request/result bundle between pipeline stall logic and divider
interface div_seq_32_if;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_seq_32.sv
// rtl/div_seq_32.sv - 32-iteration restoring divider (DIV/DIVU) around a shared add/sub
module addsub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub_ctrl,
    output logic [31:0] s,
    output logic        cf,
    output logic        of
);
    logic [31:0] b_eff;
    logic        carry;

    assign b_eff        = b ^ {32{sub_ctrl}};
    assign {carry, s}   = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub_ctrl};
    // For subtraction cf reports borrow, i.e. the inverted carry-out.
    assign cf           = carry ^ sub_ctrl;
    assign of           = (a[31] == b_eff[31]) && (s[31] != a[31]);
endmodule

module div_seq_32 #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    div_seq_32_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]       state;
    logic [4:0]       cnt;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [WIDTH-1:0] quot_q, rem_q;
    logic             sgn_q, neg_q, neg_r, dz_q;

    logic [WIDTH-1:0] add_a, add_s, abs_a, abs_b;
    logic             add_cf, adder_of_unused, ok;

    assign add_a = {r_q[WIDTH-2:0], q_q[WIDTH-1]};

    addsub_32 u_addsub (
        .a        (add_a),
        .b        (d_q),
        .sub_ctrl (1'b1),
        .s        (add_s),
        .cf       (add_cf),
        .of       (adder_of_unused)
    );

    // A set R[31] means the shifted partial remainder exceeds 32 bits, so it always covers D.
    assign ok    = r_q[WIDTH-1] | ~add_cf;
    assign abs_a = (sgn_q && op_a[WIDTH-1]) ? (~op_a + 1'b1) : op_a;
    assign abs_b = (sgn_q && op_b[WIDTH-1]) ? (~op_b + 1'b1) : op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_a   <= '0;
            op_b   <= '0;
            r_q    <= '0;
            q_q    <= '0;
            d_q    <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            sgn_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        op_a   <= bus.dividend;
                        op_b   <= bus.divisor;
                        sgn_q  <= bus.is_signed;
                        quot_q <= '0;
                        rem_q  <= '0;
                        dz_q   <= 1'b0;
                        state  <= S_PREP;
                    end
                end
                S_PREP: begin
                    if (op_b == '0) begin
                        quot_q <= '1;
                        rem_q  <= op_a;
                        dz_q   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        r_q   <= '0;
                        q_q   <= abs_a;
                        d_q   <= abs_b;
                        neg_q <= sgn_q & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        neg_r <= sgn_q & op_a[WIDTH-1];
                        cnt   <= '0;
                        state <= S_ITER;
                    end
                end
                S_ITER: begin
                    r_q <= ok ? add_s : add_a;
                    q_q <= {q_q[WIDTH-2:0], ok};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    quot_q <= neg_q ? (~q_q + 1'b1) : q_q;
                    rem_q  <= neg_r ? (~r_q + 1'b1) : r_q;
                    state  <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_DONE);
    assign bus.quotient  = quot_q;
    assign bus.remainder = rem_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_div_seq_32.sv
// tb/tb_div_seq_32.sv - scoreboard bench for div_seq_32
module tb_div_seq_32;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_seq_32_if bus ();

    div_seq_32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // lat = posedges after the accept edge until the edge that opens the done cycle
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t e;
        if (b == 32'd0) begin
            e.q = 32'hFFFFFFFF; e.r = a; e.dz = 1'b1; e.lat = 1;
        end else begin
            e.dz = 1'b0; e.lat = 34;
            if (!s) begin
                e.q = a / b; e.r = a % b;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                e.q = 32'h80000000; e.r = 32'd0;
            end else begin
                e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b);
            end
        end
        return e;
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
        bus.dividend = a; bus.divisor = b; bus.is_signed = s; bus.start = 1'b1;
        sb.push_back(model(a, b, s));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int off, output int bc, output bit got);
        off = 0;
        bc  = bus.busy ? 1 : 0;
        got = bus.done;
        while (!got && off < 60) begin
            @(negedge clk);
            off++;
            if (bus.busy) bc++;
            got = bus.done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL reset_quot got %h want 0", bus.quotient); end
        checks++; if (bus.remainder !== 32'd0) begin errors++; $display("FAIL reset_rem got %h want 0", bus.remainder); end
        checks++; if (bus.div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got %b want 0", bus.div_zero); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [31:0] ta[5] = '{32'd100, 32'hFFFFFFFF, 32'd0, 32'h12345678, 32'hDEADBEEF};
        logic [31:0] tb[5] = '{32'd7, 32'h80000001, 32'd5, 32'd1, 32'hDEADBEEF};
        int off, bc; bit got; exp_t e;
        for (int i = 0; i < 7; i++) begin
            if (i < 5) issue(ta[i], tb[i], 1'b0);
            else issue($urandom, $urandom | 32'd1, 1'b0);
            wait_done(off, bc, got);
            e = sb.pop_front();
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL u%0d_done_timeout got 0 want 1", i); end
            checks++; if (off !== e.lat) begin errors++; $display("FAIL u%0d_latency got %0d want %0d", i, off, e.lat); end
            checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL u%0d_quot got %h want %h", i, bus.quotient, e.q); end
            checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL u%0d_rem got %h want %h", i, bus.remainder, e.r); end
            checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL u%0d_dz got %b want %b", i, bus.div_zero, e.dz); end
            if (i == 0) begin
                checks++; if (bc !== 35) begin errors++; $display("FAIL u0_busy_cycles got %0d want 35", bc); end
            end
            @(negedge clk);
            checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL u%0d_pulse done=%b busy=%b want 0 0", i, bus.done, bus.busy); end
            bus.dividend = 32'h55555555; bus.divisor = 32'd3;
            repeat (3) @(negedge clk);
            checks++; if (bus.quotient !== e.q || bus.remainder !== e.r) begin errors++; $display("FAIL u%0d_hold got %h/%h want %h/%h", i, bus.quotient, bus.remainder, e.q, e.r); end
        end
    endtask

    task automatic test_signed();
        logic [31:0] ta[6] = '{-32'sd7, 32'd7, 32'h80000000, 32'h80000000, -32'sd100, 32'd12};
        logic [31:0] tb[6] = '{32'd2, -32'sd2, 32'hFFFFFFFF, 32'd1, -32'sd9, 32'd5};
        int off, bc; bit got; exp_t e;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) issue(ta[i], tb[i], 1'b1);
            else issue($urandom, $urandom | 32'd1, 1'b1);
            wait_done(off, bc, got);
            e = sb.pop_front();
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL s%0d_done_timeout got 0 want 1", i); end
            checks++; if (off !== e.lat) begin errors++; $display("FAIL s%0d_latency got %0d want %0d", i, off, e.lat); end
            checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL s%0d_quot got %h want %h", i, bus.quotient, e.q); end
            checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL s%0d_rem got %h want %h", i, bus.remainder, e.r); end
            checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL s%0d_dz got %b want %b", i, bus.div_zero, e.dz); end
            @(negedge clk);
        end
    endtask

    task automatic test_div_zero();
        logic [31:0] ta[3] = '{32'd1234, -32'sd5, 32'd0};
        logic        ts[3] = '{1'b0, 1'b1, 1'b1};
        int off, bc; bit got; exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue(ta[i], 32'd0, ts[i]);
            wait_done(off, bc, got);
            e = sb.pop_front();
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL z%0d_done_timeout got 0 want 1", i); end
            checks++; if (off !== e.lat) begin errors++; $display("FAIL z%0d_latency got %0d want %0d", i, off, e.lat); end
            checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL z%0d_quot got %h want %h", i, bus.quotient, e.q); end
            checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL z%0d_rem got %h want %h", i, bus.remainder, e.r); end
            checks++; if (bus.div_zero !== e.dz) begin errors++; $display("FAIL z%0d_dz got %b want %b", i, bus.div_zero, e.dz); end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore_start();
        int off, bc; bit got; exp_t e;
        issue(32'd100, 32'd7, 1'b0);
        repeat (4) @(negedge clk);
        bus.dividend = 32'd9; bus.divisor = 32'd3; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(off, bc, got);
        e = sb.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL ign_done_timeout got 0 want 1"); end
        checks++; if (bus.quotient !== e.q) begin errors++; $display("FAIL ign_quot got %h want %h", bus.quotient, e.q); end
        checks++; if (bus.remainder !== e.r) begin errors++; $display("FAIL ign_rem got %h want %h", bus.remainder, e.r); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int dcount;
        exp_t e;
        issue(32'd100, 32'd7, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        e = sb.pop_back();
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", bus.busy); end
        checks++; if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.div_zero !== 1'b0)
            begin errors++; $display("FAIL rmid_outputs got %h/%h/%b want 0/0/0 (discarded %h)", bus.quotient, bus.remainder, bus.div_zero, e.q); end
        dcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcount++;
        end
        checks++; if (dcount !== 0) begin errors++; $display("FAIL rmid_no_done got %0d active cycles want 0", dcount); end
        issue(32'd9, 32'd3, 1'b0);
        begin
            int off, bc; bit got;
            wait_done(off, bc, got);
            e = sb.pop_front();
            checks++; if (got !== 1'b1) begin errors++; $display("FAIL rmid_next_timeout got 0 want 1"); end
            checks++; if (bus.quotient !== e.q || bus.remainder !== e.r)
                begin errors++; $display("FAIL rmid_next got %h/%h want %h/%h", bus.quotient, bus.remainder, e.q, e.r); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int off, bc; bit got; exp_t e;
        issue(32'd1000, 32'd3, 1'b0);
        wait_done(off, bc, got);
        e = sb.pop_front();
        checks++; if (got !== 1'b1 || bus.quotient !== e.q || bus.remainder !== e.r)
            begin errors++; $display("FAIL b2b_first got %h/%h want %h/%h", bus.quotient, bus.remainder, e.q, e.r); end
        bus.dividend = -32'sd100; bus.divisor = 32'd9; bus.is_signed = 1'b1; bus.start = 1'b1;
        sb.push_back(model(-32'sd100, 32'd9, 1'b1));
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_done_start_ignored busy got %b want 0", bus.busy); end
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept busy got %b want 1", bus.busy); end
        checks++; if (bus.quotient !== 32'd0) begin errors++; $display("FAIL b2b_clear got %h want 0", bus.quotient); end
        wait_done(off, bc, got);
        e = sb.pop_front();
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL b2b_second_timeout got 0 want 1"); end
        checks++; if (off !== e.lat) begin errors++; $display("FAIL b2b_latency got %0d want %0d", off, e.lat); end
        checks++; if (bus.quotient !== e.q || bus.remainder !== e.r)
            begin errors++; $display("FAIL b2b_second got %h/%h want %h/%h", bus.quotient, bus.remainder, e.q, e.r); end
        @(negedge clk);
    endtask

    initial begin
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
